serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 Port: Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: Start  input  1  request to begin an operation; sampled on Clk rising edge.
REQ-005 Port: Sub  input  1  mode: 0 = add, 1 = subtract; sampled with Start.
REQ-006 Port: In1  input  WIDTH  first operand; sampled with Start.
REQ-007 Port: In2  input  WIDTH  second operand; sampled with Start.
REQ-008 Port: Cin  input  1  carry-in for add mode; sampled with Start; ignored in subtract mode.
REQ-009 Port: Busy  output  1  high while an operation is in progress.
REQ-010 Port: Done  output  1  single-cycle pulse marking a new valid result.
REQ-011 Port: Sum  output  WIDTH  result, held until the next result is produced.
REQ-012 Port: Cout  output  1  carry out of the MSB; in subtract mode, 1 = no borrow.
REQ-013 Port: Ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-014 The block SHALL compute the result bit-serially, LSB first, using one full-adder stage, one bit per clock.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; the reset state is IDLE.
REQ-016 IDLE -> RUN on a rising edge with Start=1; In1, In2, Sub, Cin SHALL be latched on that edge.
REQ-017 Add mode: result = In1 + In2 + Cin; subtract mode: result = In1 + ~In2 + 1, with Cin ignored.
REQ-018 RUN SHALL last exactly WIDTH clocks; a bit counter counts 0..WIDTH-1, and RUN -> DONE on the edge that processes bit WIDTH-1.
REQ-019 On the RUN -> DONE edge, Sum, Cout and Ovf SHALL be updated together.
REQ-020 Ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-021 DONE SHALL last one clock and then go to IDLE unconditionally.
REQ-022 Done=1 exactly in DONE; Busy=1 exactly in RUN.
REQ-023 Latency: Start sampled at edge N gives Done=1 in the cycle following edge N+WIDTH.
REQ-024 Start SHALL be ignored in RUN and in DONE; latched operands SHALL not change during an operation.
REQ-025 Sum, Cout and Ovf SHALL hold their previous values throughout RUN and IDLE; partial results SHALL never be visible.
REQ-026 In1, In2, Cin and Sub SHALL be don't-care except on the Start-accepting edge.
REQ-027 Back-to-back operation: Start held high SHALL be accepted on the first edge in IDLE after DONE, giving one result every WIDTH+2 cycles.
REQ-028 Counter and carry width SHALL be sized from WIDTH, with no wrap-around before WIDTH bits are processed.

Reset
REQ-029 Rst_n=0 SHALL immediately, independent of Clk, force the state to IDLE and clear the counter, the carry and all operand and shift registers.
REQ-030 Reset values: Busy=0, Done=0, Sum=0, Cout=0, Ovf=0.
REQ-031 Reset asserted mid-RUN SHALL abort the operation: no Done pulse, and outputs are zero.
REQ-032 After Rst_n deasserts, Start SHALL be accepted on the first rising edge.

Verification (WIDTH=8)
REQ-033 Add 8'h0F + 8'h01, Cin=0 -> Sum=8'h10, Cout=0, Ovf=0; Busy high for 8 cycles; Done pulses in the cycle after edge N+8.
REQ-034 Add 8'hFF + 8'h01, Cin=1 -> Sum=8'h01, Cout=1, Ovf=0; add 8'h7F + 8'h01, Cin=0 -> Sum=8'h80, Cout=0, Ovf=1.
REQ-035 Sub 8'h05 - 8'h07 with Cin=1 -> Sum=8'hFE, Cout=0, Ovf=0; sub 8'h80 - 8'h01 -> Sum=8'h7F, Cout=1, Ovf=1.
REQ-036 Start pulsed with new operands during RUN and during DONE -> ignored; the first result is unchanged; Sum holds its old value until the Done cycle.
REQ-037 Rst_n pulsed low at RUN bit 4 -> Busy, Done, Sum, Cout and Ovf all 0 at once, no Done pulse; the next Start completes normally.
REQ-038 Exhaustive sweep at WIDTH=2 and WIDTH=3, over all In1, In2, Cin and Sub with Start held high -> every result matches a reference model, and results arrive every WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_adder.sv
`default_nettype none
// =============================================================================
// serial_adder : bit-serial add/subtract, LSB first, one full-adder per clock
// Rev 1.0
// =============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int               CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             w_sum_bit;
  logic             w_carry_out;

  assign w_sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
  assign w_carry_out = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = In1;
          // Subtraction is In1 + ~In2 + 1, so the +1 rides in on the carry.
          b_d     = Sub ? ~In2 : In2;
          carry_d = Sub ? 1'b1 : Cin;
          acc_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = w_carry_out;
        acc_d   = {w_sum_bit, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST_BIT) begin
          state_d = DONE;
          cnt_d   = '0;
          sum_d   = {w_sum_bit, acc_q[WIDTH-1:1]};
          cout_d  = w_carry_out;
          // carry_q is the carry into the MSB while the MSB is being added.
          ovf_d   = carry_q ^ w_carry_out;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Busy = (state_q == RUN);
  assign Done = (state_q == DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// =============================================================================
// tb_serial_adder : self-checking bench for serial_adder at WIDTH 8, 2 and 3
// Rev 1.0
// =============================================================================
module tb_serial_adder;

  logic clk;
  logic rst_n;

  logic       d8_start, d8_sub, d8_cin, d8_busy, d8_done, d8_cout, d8_ovf;
  logic [7:0] d8_in1, d8_in2, d8_sum;
  logic       d2_start, d2_sub, d2_cin, d2_busy, d2_done, d2_cout, d2_ovf;
  logic [1:0] d2_in1, d2_in2, d2_sum;
  logic       d3_start, d3_sub, d3_cin, d3_busy, d3_done, d3_cout, d3_ovf;
  logic [2:0] d3_in1, d3_in2, d3_sum;

  int total;
  int passed;
  int failed;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Rst_n(rst_n), .Start(d8_start), .Sub(d8_sub),
    .In1(d8_in1), .In2(d8_in2), .Cin(d8_cin),
    .Busy(d8_busy), .Done(d8_done), .Sum(d8_sum), .Cout(d8_cout), .Ovf(d8_ovf)
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .Clk(clk), .Rst_n(rst_n), .Start(d2_start), .Sub(d2_sub),
    .In1(d2_in1), .In2(d2_in2), .Cin(d2_cin),
    .Busy(d2_busy), .Done(d2_done), .Sum(d2_sum), .Cout(d2_cout), .Ovf(d2_ovf)
  );

  serial_adder #(.WIDTH(3)) u_dut3 (
    .Clk(clk), .Rst_n(rst_n), .Start(d3_start), .Sub(d3_sub),
    .In1(d3_in1), .In2(d3_in2), .Cin(d3_cin),
    .Busy(d3_busy), .Done(d3_done), .Sum(d3_sum), .Cout(d3_cout), .Ovf(d3_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic; overflow from the operand/result sign rule.
  function automatic logic [65:0] ref_op(input int w, input logic [63:0] a,
                                         input logic [63:0] b, input logic sub,
                                         input logic cin);
    logic [63:0] mask, am, bb, s;
    logic [64:0] full;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    am   = a & mask;
    bb   = sub ? (~b & mask) : (b & mask);
    full = {1'b0, am} + {1'b0, bb} + (sub ? 65'd1 : {64'd0, cin});
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
    return {ov, co, s};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge with the WIDTH=8 DUT idle; returns just after a negedge.
  task automatic run8(input logic sub, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic [7:0] es, input logic ec,
                      input logic eo, input string tag);
    logic [7:0] old_sum;
    int         busy_n;
    int         lat;
    logic       held;
    old_sum  = d8_sum;
    d8_start = 1'b1; d8_sub = sub; d8_in1 = a; d8_in2 = b; d8_cin = cin;
    @(posedge clk);
    @(negedge clk);
    d8_start = 1'b0;
    d8_in1 = 8'($urandom); d8_in2 = 8'($urandom);
    d8_sub = 1'($urandom); d8_cin = 1'($urandom);
    busy_n = 0; lat = 1; held = 1'b1;
    while (!d8_done && lat < 40) begin
      if (d8_busy) busy_n++;
      if (d8_sum !== old_sum) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd9);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd8);
    check({tag, "_sum_held"}, 64'(held), 64'd1);
    check({tag, "_busy_in_done"}, 64'(d8_busy), 64'd0);
    check({tag, "_sum"}, 64'(d8_sum), 64'(es));
    check({tag, "_cout"}, 64'(d8_cout), 64'(ec));
    check({tag, "_ovf"}, 64'(d8_ovf), 64'(eo));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(d8_done), 64'd0);
  endtask

  initial begin
    logic [65:0] r;
    logic [7:0]  ra, rb, prev;
    logic        rs, rc, saw;
    int          lat;

    total = 0; passed = 0; failed = 0;
    rst_n = 1'b0;
    d8_start = 1'b0; d8_sub = 1'b0; d8_cin = 1'b0; d8_in1 = '0; d8_in2 = '0;
    d2_start = 1'b0; d2_sub = 1'b0; d2_cin = 1'b0; d2_in1 = '0; d2_in2 = '0;
    d3_start = 1'b0; d3_sub = 1'b0; d3_cin = 1'b0; d3_in1 = '0; d3_in2 = '0;

    repeat (3) @(negedge clk);
    check("reset_busy", 64'(d8_busy), 64'd0);
    check("reset_done", 64'(d8_done), 64'd0);
    check("reset_sum", 64'(d8_sum), 64'd0);
    check("reset_cout", 64'(d8_cout), 64'd0);
    check("reset_ovf", 64'(d8_ovf), 64'd0);
    rst_n = 1'b1;

    // Start on the very first edge after reset release.
    run8(1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01");
    run8(1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, "add_ff_01_c");
    run8(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01");
    run8(1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07");
    run8(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, "sub_80_01");

    for (int i = 0; i < 25; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      r  = ref_op(8, 64'(ra), 64'(rb), rs, rc);
      run8(rs, ra, rb, rc, r[7:0], r[64], r[65], "rand");
    end

    // Start during RUN and during DONE must be ignored.
    prev = d8_sum;
    d8_start = 1'b1; d8_sub = 1'b0; d8_in1 = 8'h12; d8_in2 = 8'h34; d8_cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    d8_start = 1'b0;
    repeat (3) @(negedge clk);
    d8_start = 1'b1; d8_sub = 1'b1; d8_in1 = 8'hAA; d8_in2 = 8'h55; d8_cin = 1'b1;
    @(negedge clk);
    d8_start = 1'b0;
    check("ign_sum_hold", 64'(d8_sum), 64'(prev));
    lat = 0;
    while (!d8_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("ign_done", 64'(d8_done), 64'd1);
    check("ign_sum", 64'(d8_sum), 64'h46);
    check("ign_cout", 64'(d8_cout), 64'd0);
    check("ign_ovf", 64'(d8_ovf), 64'd0);
    d8_start = 1'b1; d8_sub = 1'b0; d8_in1 = 8'hF0; d8_in2 = 8'hF0; d8_cin = 1'b1;
    @(negedge clk);
    d8_start = 1'b0;
    check("ign_done_busy", 64'(d8_busy), 64'd0);
    @(negedge clk);
    check("ign_idle_busy", 64'(d8_busy), 64'd0);
    check("ign_sum_after", 64'(d8_sum), 64'h46);

    // Asynchronous reset in the middle of RUN.
    d8_start = 1'b1; d8_sub = 1'b0; d8_in1 = 8'h3C; d8_in2 = 8'h5A; d8_cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    d8_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pre_busy", 64'(d8_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(d8_busy), 64'd0);
    check("rst_done", 64'(d8_done), 64'd0);
    check("rst_sum", 64'(d8_sum), 64'd0);
    check("rst_cout", 64'(d8_cout), 64'd0);
    check("rst_ovf", 64'(d8_ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (d8_done) saw = 1'b1;
    end
    check("rst_no_done", 64'(saw), 64'd0);
    run8(1'b0, 8'h3C, 8'h5A, 1'b1, 8'h97, 1'b0, 1'b1, "post_rst");

    // Exhaustive sweeps with Start held high: period of WIDTH+2 cycles.
    d2_start = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 4; a++)
          for (int b = 0; b < 4; b++) begin
            d2_sub = 1'(s); d2_cin = 1'(c); d2_in1 = 2'(a); d2_in2 = 2'(b);
            r = ref_op(2, 64'(a), 64'(b), 1'(s), 1'(c));
            @(posedge clk);
            lat = 0;
            do begin
              @(negedge clk);
              lat++;
            end while (!d2_done && lat < 20);
            check("w2_latency", 64'(lat), 64'd3);
            check("w2_sum", 64'(d2_sum), 64'(r[1:0]));
            check("w2_cout", 64'(d2_cout), 64'(r[64]));
            check("w2_ovf", 64'(d2_ovf), 64'(r[65]));
            @(negedge clk);
          end
    d2_start = 1'b0;

    d3_start = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 8; a++)
          for (int b = 0; b < 8; b++) begin
            d3_sub = 1'(s); d3_cin = 1'(c); d3_in1 = 3'(a); d3_in2 = 3'(b);
            r = ref_op(3, 64'(a), 64'(b), 1'(s), 1'(c));
            @(posedge clk);
            lat = 0;
            do begin
              @(negedge clk);
              lat++;
            end while (!d3_done && lat < 20);
            check("w3_latency", 64'(lat), 64'd4);
            check("w3_sum", 64'(d3_sum), 64'(r[2:0]));
            check("w3_cout", 64'(d3_cout), 64'(r[64]));
            check("w3_ovf", 64'(d3_ovf), 64'(r[65]));
            @(negedge clk);
          end
    d3_start = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
